alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_mul_seq.sv | 80 ++++++++
 rtl/alu_pipe.sv | 145 ++++++++++++++
 tb/tb_alu_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined ALU: opcodes, FSM states and the default datapath width.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_MUL = 3'b011,
    OP_NOR = 3'b100,
    OP_XOR = 3'b101,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle over WIDTH cycles.
// Signed operands are multiplied as magnitudes and the result negated when the signs differ.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             unsig,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_step, full_s;
  logic [WIDTH-1:0]   mplier_q, mplier_d, mag_a, mag_b;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d, neg_q, neg_d, unsig_q, unsig_d;

  always_comb begin
    mag_a    = (!unsig && a[WIDTH-1]) ? -a : a;
    mag_b    = (!unsig && b[WIDTH-1]) ? -b : b;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    neg_d    = neg_q;
    unsig_d  = unsig_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    // done is raised during the final step so the caller can capture acc_step directly
    done     = busy_q && (cnt_q == CW'(WIDTH - 1));
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, mag_a};
      mplier_d = mag_b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
      neg_d    = !unsig && (a[WIDTH-1] ^ b[WIDTH-1]);
      unsig_d  = unsig;
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = done ? '0 : cnt_q + CW'(1);
      busy_d   = !done;
    end
    full_s   = neg_q ? -acc_step : acc_step;
    product  = full_s[WIDTH-1:0];
    overflow = unsig_q ? |acc_step[2*WIDTH-1:WIDTH]
                       : (full_s[2*WIDTH-1:WIDTH] != {WIDTH{full_s[WIDTH-1]}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      neg_q    <= 1'b0;
      unsig_q  <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      neg_q    <= neg_d;
      unsig_q  <= unsig_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Single-stage ALU with valid/ready handshake, sticky overflow and an optional iterative multiplier.
// Define ALU_PIPE_MUL_EN to build the multiplier; otherwise op MUL returns zero in one cycle.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             unsig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout,
  output logic             overflow,
  output logic             compout,
  output logic             ovf_sticky,
  input  logic             ovf_clear
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aluout_q, aluout_d, res, diff;
  logic [WIDTH:0]   sum;
  logic             overflow_q, overflow_d, compout_q, compout_d, sticky_q, sticky_d;
  logic             res_ovf, lt, accept;
  op_e              op_s;

  assign op_s       = op_e'(op);
  assign in_ready   = (state_q == S_IDLE) || ((state_q == S_OUT) && out_ready);
  assign out_valid  = (state_q == S_OUT);
  assign accept     = in_valid && in_ready;
  assign aluout     = aluout_q;
  assign overflow   = overflow_q;
  assign compout    = compout_q;
  assign ovf_sticky = sticky_q;

`ifdef ALU_PIPE_MUL_EN
  logic             mul_start, mul_done, mul_ovf;
  logic [WIDTH-1:0] mul_product;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .reset    (reset),
    .start    (mul_start),
    .a        (a),
    .b        (b),
    .unsig    (unsig),
    .done     (mul_done),
    .product  (mul_product),
    .overflow (mul_ovf)
  );
`endif

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = a - b;
    lt      = unsig ? (a < b) : ($signed(a) < $signed(b));
    res     = '0;
    res_ovf = 1'b0;
    case (op_s)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_NOR: res = ~(a | b);
      OP_XOR: res = a ^ b;
      OP_ADD: begin
        res     = sum[WIDTH-1:0];
        res_ovf = unsig ? sum[WIDTH]
                        : (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res     = diff;
        res_ovf = unsig ? (a < b)
                        : (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: res = {{(WIDTH-1){1'b0}}, lt};
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    aluout_d   = aluout_q;
    overflow_d = overflow_q;
    compout_d  = compout_q;
`ifdef ALU_PIPE_MUL_EN
    mul_start  = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_OUT: begin
        if (accept) begin
          compout_d = lt;
`ifdef ALU_PIPE_MUL_EN
          if (op_s == OP_MUL) begin
            state_d   = S_MUL;
            mul_start = 1'b1;
          end else
`endif
          begin
            state_d    = S_OUT;
            aluout_d   = res;
            overflow_d = res_ovf;
          end
        end else if ((state_q == S_OUT) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
`ifdef ALU_PIPE_MUL_EN
        if (mul_done) begin
          state_d    = S_OUT;
          aluout_d   = mul_product;
          overflow_d = mul_ovf;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // a new overflow beats a simultaneous clear so no event is lost
    sticky_d = (out_valid && out_ready && overflow_q) ? 1'b1 :
               ovf_clear                              ? 1'b0 : sticky_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      aluout_q   <= '0;
      overflow_q <= 1'b0;
      compout_q  <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      aluout_q   <= aluout_d;
      overflow_q <= overflow_d;
      compout_q  <= compout_d;
      sticky_q   <= sticky_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=32): directed corner cases plus randomized traffic.
module tb_alu_pipe;

  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready, unsig = 1'b0;
  logic        out_valid, out_ready = 1'b0, overflow, compout, ovf_sticky, ovf_clear = 1'b0;
  logic [31:0] a = '0, b = '0, aluout;
  logic [2:0]  op = '0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .unsig(unsig), .out_valid(out_valid), .out_ready(out_ready),
    .aluout(aluout), .overflow(overflow), .compout(compout),
    .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        cmp;
  } exp_t;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  exp_t q[$];
  int   checks = 0, failures = 0, cyc = 0, acc_cyc = 0, first = 0;
  int   accs[4];
  bit   rdy_rand = 0, sticky_m = 0, mon_set = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: results from integer arithmetic, overflow as "does not fit the range".
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic u);
    exp_t e;
    longint sx, sy, r;
    longint unsigned ux, uy, ur;
    sx = $signed(x); sy = $signed(y);
    ux = {32'd0, x}; uy = {32'd0, y};
    e.res = '0; e.ovf = 1'b0;
    e.cmp = u ? (ux < uy) : (sx < sy);
    case (o)
      3'd0: e.res = x & y;
      3'd1: e.res = x | y;
      3'd4: e.res = ~(x | y);
      3'd5: e.res = x ^ y;
      3'd2: if (u) begin ur = ux + uy; e.res = ur[31:0]; e.ovf = ur > 64'hFFFF_FFFF; end
            else begin r = sx + sy; e.res = r[31:0]; e.ovf = (r > MAXS) || (r < MINS); end
      3'd6: if (u) begin ur = ux - uy; e.res = ur[31:0]; e.ovf = ux < uy; end
            else begin r = sx - sy; e.res = r[31:0]; e.ovf = (r > MAXS) || (r < MINS); end
      3'd7: e.res = {31'd0, e.cmp};
`ifdef ALU_PIPE_MUL_EN
      3'd3: if (u) begin ur = ux * uy; e.res = ur[31:0]; e.ovf = ur > 64'hFFFF_FFFF; end
            else begin r = sx * sy; e.res = r[31:0]; e.ovf = (r > MAXS) || (r < MINS); end
`endif
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: compare whatever is presented against the queue head; pop on transfer.
  always @(negedge clk) begin
    if (reset) begin
      sticky_m = 1'b0;
    end else begin
      check("ovf_sticky", ovf_sticky, sticky_m);
      mon_set = 1'b0;
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output got=%0h exp=none", aluout);
        end else begin
          check("aluout", aluout, q[0].res);
          check("overflow", overflow, q[0].ovf);
          check("compout", compout, q[0].cmp);
          if (out_ready) begin
            mon_set = q[0].ovf;
            void'(q.pop_front());
          end
        end
      end
      if (mon_set) sticky_m = 1'b1;
      else if (ovf_clear) sticky_m = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic u);
    int n = 0;
    bit ok = 0;
    op = o; a = x; b = y; unsig = u; in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else begin n++; tick(); end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout got=in_ready_low exp=accept");
      in_valid = 1'b0;
    end else begin
      acc_cyc = cyc;
      @(posedge clk);
      q.push_back(model(o, x, y, u));
      #1;
      in_valid = 1'b0;
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drain();
    int n = 0;
    rdy_rand = 0; out_ready = 1'b1;
    while (q.size() != 0 && n < 500) begin tick(); n++; end
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout got=%0d exp=0", q.size());
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_aluout", aluout, 0);
    check("rst_overflow", overflow, 0);
    check("rst_compout", compout, 0);
    check("rst_sticky", ovf_sticky, 0);

    // signed add overflow, latency 1, sticky after transfer
    out_ready = 1'b1;
    send(3'd2, 32'h7FFF_FFFF, 32'h1, 1'b0);
    check("add_lat1_valid", out_valid, 1);
    check("add_lat1_res", aluout, 32'h8000_0000);
    tick();
    check("add_sticky", ovf_sticky, 1);

    // 3 - 5 unsigned then signed
    send(3'd6, 32'd3, 32'd5, 1'b1);
    send(3'd6, 32'd3, 32'd5, 1'b0);
    drain();

    // back-to-back ANDs then a 3-cycle stall
    for (int i = 0; i < 4; i++) begin
      send(3'd0, $urandom, $urandom, 1'b0);
      accs[i] = acc_cyc;
    end
    for (int i = 1; i < 4; i++) check("b2b_accept_gap", accs[i] - accs[i-1], 1);
    out_ready = 1'b0;
    op = 3'd1; a = $urandom; b = $urandom; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    drain();

    // clear colliding with an overflowing transfer
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    check("clear_sticky", ovf_sticky, 0);
    out_ready = 1'b0;
    send(3'd2, 32'h7FFF_FFFF, 32'h1, 1'b0);
    ovf_clear = 1'b1; out_ready = 1'b1;
    tick();
    check("sticky_set_wins", ovf_sticky, 1);
    tick();
    check("sticky_clear_alone", ovf_sticky, 0);
    ovf_clear = 1'b0;

`ifdef ALU_PIPE_MUL_EN
    drain();
    send(3'd3, 32'h0001_0000, 32'h0001_0000, 1'b1);
    first = 0;
    for (int i = 2; i <= 40 && first == 0; i++) begin
      tick();
      if (out_valid) first = i;
    end
    check("mul_latency", first, 33);
    send(3'd3, 32'd6, -32'sd7, 1'b0);
    drain();

    // reset in the middle of a multiply
    send(3'd3, 32'd123, 32'd456, 1'b0);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    check("mulrst_out_valid", out_valid, 0);
    check("mulrst_in_ready", in_ready, 1);
    check("mulrst_sticky", ovf_sticky, 0);
    send(3'd2, 32'd2, 32'd3, 1'b0);
    drain();
`endif

    // randomized traffic with random back-pressure and clears
    rdy_rand = 1;
    for (int i = 0; i < 300; i++) begin
      ovf_clear = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) tick();
      send(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
    end
    ovf_clear = 1'b0;
    drain();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
